// File: rtl/ecg_thr_window_ctrl.sv
// Window sequencer for the ECG max/min threshold datapath: drives count1/count2,
// tracks running min/max sample positions and hands captured thresholds downstream.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no run active, counters at 0
// S_RUN  | collecting samples of window count1, count2 counts down
// S_CAPT | one-cycle capture of thr1_in/thr2_in, count2 == 1
// S_DONE | all windows of the run captured, waiting for start
module ecg_thr_window_ctrl #(
    parameter int N3      = 256,
    parameter int NUM_WIN = 8
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               start,
    input  logic               abort,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic signed [15:0] data_in,
    input  logic        [15:0] thr1_in,
    input  logic        [15:0] thr2_in,
    output logic        [3:0]  count1,
    output logic        [8:0]  count2,
    output logic        [15:0] min_pos_l3,
    output logic        [15:0] max_pos_l3,
    output logic        [15:0] thr1,
    output logic        [15:0] thr2,
    output logic               thr_valid,
    input  logic               thr_ready,
    output logic               thr_overrun,
    output logic               busy,
    output logic               done
);

    localparam logic [8:0] C_N3      = 9'(N3);
    localparam logic [3:0] C_NUM_WIN = 4'(NUM_WIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic        [3:0]  r_count1;
    logic        [8:0]  r_count2;
    logic        [15:0] r_samp_idx;
    logic               r_first;
    logic signed [15:0] r_shmax;
    logic signed [15:0] r_shmin;
    logic        [15:0] r_max_pos;
    logic        [15:0] r_min_pos;
    logic        [15:0] r_thr1;
    logic        [15:0] r_thr2;
    logic               r_thr_valid;
    logic               r_thr_overrun;

    logic               w_ready;
    logic               w_accept;
    logic               w_start;
    logic               w_capture;
    logic               w_last_win;

    assign w_accept   = sample_valid && w_ready;
    assign w_last_win = (r_count1 == C_NUM_WIN);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept && (r_count2 == 9'd2)) begin
                        w_state_nxt = S_CAPT;
                    end
                end
                S_CAPT: begin
                    w_state_nxt = w_last_win ? S_DONE : S_RUN;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready   = (r_state == S_RUN);
        busy      = (r_state == S_RUN) || (r_state == S_CAPT);
        done      = (r_state == S_DONE);
        w_start   = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_capture = (r_state == S_CAPT) && !abort;
    end

    // ---------------- window counters ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_count1 <= 4'd0;
            r_count2 <= 9'd0;
        end else if (abort) begin
            r_count1 <= 4'd0;
            r_count2 <= 9'd0;
        end else if (w_start) begin
            r_count1 <= 4'd1;
            r_count2 <= C_N3;
        end else begin
            case (r_state)
                S_RUN: begin
                    // N3..3 step down, 2 steps to 1 (capture); both are a decrement
                    if (w_accept) begin
                        r_count2 <= r_count2 - 9'd1;
                    end
                end
                S_CAPT: begin
                    if (w_last_win) begin
                        r_count1 <= 4'd0;
                        r_count2 <= 9'd0;
                    end else begin
                        r_count1 <= r_count1 + 4'd1;
                        r_count2 <= C_N3;
                    end
                end
                default: begin
                    r_count1 <= r_count1;
                    r_count2 <= r_count2;
                end
            endcase
        end
    end

    // ---------------- running min/max position tracking ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_samp_idx <= 16'd0;
            r_first    <= 1'b0;
            r_shmax    <= 16'sd0;
            r_shmin    <= 16'sd0;
            r_max_pos  <= 16'd0;
            r_min_pos  <= 16'd0;
        end else if (w_start) begin
            r_samp_idx <= 16'd0;
            r_first    <= 1'b1;
        end else if (w_accept) begin
            r_samp_idx <= r_samp_idx + 16'd1;
            // shadows span the whole run, so ties keep the earliest index
            if (r_first) begin
                r_first   <= 1'b0;
                r_shmax   <= data_in;
                r_shmin   <= data_in;
                r_max_pos <= r_samp_idx;
                r_min_pos <= r_samp_idx;
            end else if (data_in > r_shmax) begin
                r_shmax   <= data_in;
                r_max_pos <= r_samp_idx;
            end else if (data_in < r_shmin) begin
                r_shmin   <= data_in;
                r_min_pos <= r_samp_idx;
            end
        end
    end

    // ---------------- threshold capture and valid/ready port ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_thr1        <= 16'd0;
            r_thr2        <= 16'd0;
            r_thr_valid   <= 1'b0;
            r_thr_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_thr1      <= thr1_in;
                r_thr2      <= thr2_in;
                r_thr_valid <= 1'b1;
                if (r_thr_valid && !thr_ready) begin
                    r_thr_overrun <= 1'b1;
                end
            end else if (r_thr_valid && thr_ready) begin
                r_thr_valid <= 1'b0;
            end
            if (w_start) begin
                r_thr_overrun <= 1'b0;
            end
        end
    end

    assign sample_ready = w_ready;
    assign count1       = r_count1;
    assign count2       = r_count2;
    assign min_pos_l3   = r_min_pos;
    assign max_pos_l3   = r_max_pos;
    assign thr1         = r_thr1;
    assign thr2         = r_thr2;
    assign thr_valid    = r_thr_valid;
    assign thr_overrun  = r_thr_overrun;

endmodule
